// File: rtl/sec_pkg.sv
// Shared encodings and default constants for the sec serial link (gen_sec transmitter, det_sec receiver).
// The PARIDAD encoding only exists when GS_PARIDAD_EN is defined.
package sec_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PAT_W_DEF  = 4;
    localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1101;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PREAMB  = 3'd1;
    localparam logic [2:0] ST_DATOS   = 3'd2;
`ifdef GS_PARIDAD_EN
    localparam logic [2:0] ST_PARIDAD = 3'd3;
`endif
    localparam logic [2:0] ST_GUARDA  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_PREAMB  = ST_PREAMB,
        S_DATOS   = ST_DATOS,
`ifdef GS_PARIDAD_EN
        S_PARIDAD = ST_PARIDAD,
`endif
        S_GUARDA  = ST_GUARDA
    } estado_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reg_desp.sv
// Parallel-load, left-shift register with serial MSB output.
// A load takes priority over a shift in the same cycle.
module reg_desp #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         carga,
    input  logic         desp,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (carga) begin
            q <= d;
        end else if (desp) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/gen_sec.sv
// Serial frame transmitter: preamble, MSB-first payload, optional even parity, idle guard bits.
// Optional parity bit is enabled with the GS_PARIDAD_EN macro.
module gen_sec
    import sec_pkg::*;
#(
    parameter int                 DATA_W  = DATA_W_DEF,
    parameter int                 PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0]   PATTERN = PATTERN_DEF,
    parameter int                 GUARD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dato_in,
    input  logic              cargar,
    output logic              listo,
    output logic              s_out,
    output logic              activo,
    output logic              fin,
    output logic [2:0]        estado
);

    localparam int CNT_MAX = max3(PAT_W, DATA_W, GUARD);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PIDX_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    // Handshake: a word is accepted on a rising edge where cargar=1 and listo=1;
    // cargar while listo=0 is dropped, and dato_in is only sampled on that edge.

    estado_e            state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s_out_d, fin_d;
    logic               carga, desp, sh_msb;

`ifdef GS_PARIDAD_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (carga) begin
            par_q <= ^dato_in;
        end
    end
`endif

    reg_desp #(.W(DATA_W)) u_desp (
        .clk   (clk),
        .rst   (rst),
        .carga (carga),
        .desp  (desp),
        .d     (dato_in),
        .msb   (sh_msb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carga   = 1'b0;
        fin_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cargar && listo) begin
                    state_d = S_PREAMB;
                    cnt_d   = CNT_W'(PAT_W - 1);
                    carga   = 1'b1;
                end
            end
            S_PREAMB: begin
                if (cnt_q == '0) begin
                    state_d = S_DATOS;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATOS: begin
                if (cnt_q == '0) begin
`ifdef GS_PARIDAD_EN
                    state_d = S_PARIDAD;
                    cnt_d   = '0;
`else
                    state_d = S_GUARDA;
                    cnt_d   = CNT_W'(GUARD - 1);
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef GS_PARIDAD_EN
            S_PARIDAD: begin
                state_d = S_GUARDA;
                cnt_d   = CNT_W'(GUARD - 1);
            end
`endif
            S_GUARDA: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The shift register consumes each payload bit on the same edge that registers it onto s_out.
        desp    = (state_d == S_DATOS);
        s_out_d = 1'b0;
        case (state_d)
            S_PREAMB:  s_out_d = PATTERN[PIDX_W'(cnt_d)];
            S_DATOS:   s_out_d = sh_msb;
`ifdef GS_PARIDAD_EN
            S_PARIDAD: s_out_d = par_q;
`endif
            default:   s_out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            s_out   <= 1'b0;
            listo   <= 1'b1;
            activo  <= 1'b0;
            fin     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_out   <= s_out_d;
            listo   <= (state_d == S_IDLE);
            activo  <= (state_d != S_IDLE);
            fin     <= fin_d;
        end
    end

    assign estado = state_q;

endmodule

// File: tb/tb_gen_sec.sv
// Directed bench for gen_sec; build with +define+GS_PARIDAD_EN to exercise the parity bit.
module tb_gen_sec;

`ifdef GS_PARIDAD_EN
    localparam int F = 15;
`else
    localparam int F = 14;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dato_in;
    logic       cargar;
    logic       listo, s_out, activo, fin;
    logic [2:0] estado;

    int checks   = 0;
    int failures = 0;

    gen_sec dut (
        .clk     (clk),
        .rst     (rst),
        .dato_in (dato_in),
        .cargar  (cargar),
        .listo   (listo),
        .s_out   (s_out),
        .activo  (activo),
        .fin     (fin),
        .estado  (estado)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected serial frame for a payload; parity words are also spelled out literally in test_parity.
    function automatic logic [F-1:0] frame_of(input logic [7:0] d);
`ifdef GS_PARIDAD_EN
        return {4'b1101, d, ^d, 2'b00};
`else
        return {4'b1101, d, 2'b00};
`endif
    endfunction

    task automatic test_reset;
        rst = 1'b0; cargar = 1'b1; dato_in = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({s_out, listo, activo, fin} !== 4'b0100) begin
                failures++;
                $display("FAIL reset c=%0d got s_out/listo/activo/fin=%b want 0100", c, {s_out, listo, activo, fin});
            end
        end
        cargar = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({s_out, listo, activo, fin} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_release got %b want 0100", {s_out, listo, activo, fin});
        end
    endtask

    task automatic test_single;
        logic [F-1:0] exp;
`ifdef GS_PARIDAD_EN
        exp = 15'b1101_10100101_0_00;
`else
        exp = 14'b1101_10100101_00;
`endif
        dato_in = 8'hA5; cargar = 1'b1;
        step();
        cargar = 1'b0; dato_in = 8'h00;
        for (int c = 1; c <= F; c++) begin
            checks++;
            if ({s_out, listo, activo, fin} !== {exp[F-c], 3'b010}) begin
                failures++;
                $display("FAIL single c=%0d got %b want %b", c, {s_out, listo, activo, fin}, {exp[F-c], 3'b010});
            end
            step();
        end
        checks++;
        if ({s_out, listo, activo, fin} !== 4'b0101) begin
            failures++;
            $display("FAIL single_fin got %b want 0101", {s_out, listo, activo, fin});
        end
        step();
        checks++;
        if ({s_out, listo, activo, fin} !== 4'b0100) begin
            failures++;
            $display("FAIL single_after_fin got %b want 0100", {s_out, listo, activo, fin});
        end
    endtask

`ifdef GS_PARIDAD_EN
    task automatic test_parity;
        logic [F-1:0] exp;
        exp = 15'b1101_00000111_1_00;
        dato_in = 8'h07; cargar = 1'b1;
        step();
        cargar = 1'b0;
        for (int c = 1; c <= F; c++) begin
            checks++;
            if ({s_out, listo, activo, fin} !== {exp[F-c], 3'b010}) begin
                failures++;
                $display("FAIL parity c=%0d got %b want %b", c, {s_out, listo, activo, fin}, {exp[F-c], 3'b010});
            end
            step();
        end
        checks++;
        if (fin !== 1'b1) begin
            failures++;
            $display("FAIL parity_fin cycle16 got fin=%b want 1", fin);
        end
        step();
    endtask
`endif

    task automatic test_busy;
        logic [F-1:0] exp;
        exp = frame_of(8'h3C);
        dato_in = 8'h3C; cargar = 1'b1;
        step();
        cargar = 1'b0; dato_in = 8'h00;
        for (int c = 1; c <= F; c++) begin
            checks++;
            if ({s_out, listo, activo, fin} !== {exp[F-c], 3'b010}) begin
                failures++;
                $display("FAIL busy c=%0d got %b want %b", c, {s_out, listo, activo, fin}, {exp[F-c], 3'b010});
            end
            if (c == 5) begin
                cargar = 1'b1; dato_in = 8'hFF;
            end else begin
                cargar = 1'b0;
            end
            step();
        end
        checks++;
        if ({s_out, listo, activo, fin} !== 4'b0101) begin
            failures++;
            $display("FAIL busy_fin got %b want 0101", {s_out, listo, activo, fin});
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({s_out, listo, activo, fin} !== 4'b0100) begin
                failures++;
                $display("FAIL busy_no_second c=%0d got %b want 0100", c, {s_out, listo, activo, fin});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [F-1:0] exp1, exp2;
        exp1 = frame_of(8'h81);
        exp2 = frame_of(8'h7E);
        dato_in = 8'h81; cargar = 1'b1;
        step();
        dato_in = 8'h7E;
        for (int c = 1; c <= F; c++) begin
            checks++;
            if ({s_out, listo, activo, fin} !== {exp1[F-c], 3'b010}) begin
                failures++;
                $display("FAIL b2b_first c=%0d got %b want %b", c, {s_out, listo, activo, fin}, {exp1[F-c], 3'b010});
            end
            step();
        end
        checks++;
        if ({s_out, listo, activo, fin} !== 4'b0101) begin
            failures++;
            $display("FAIL b2b_gap got %b want 0101", {s_out, listo, activo, fin});
        end
        step();
        cargar = 1'b0; dato_in = 8'h00;
        for (int c = 1; c <= F; c++) begin
            checks++;
            if ({s_out, listo, activo, fin} !== {exp2[F-c], 3'b010}) begin
                failures++;
                $display("FAIL b2b_second c=%0d got %b want %b", c, {s_out, listo, activo, fin}, {exp2[F-c], 3'b010});
            end
            step();
        end
        checks++;
        if ({s_out, listo, activo, fin} !== 4'b0101) begin
            failures++;
            $display("FAIL b2b_second_fin got %b want 0101", {s_out, listo, activo, fin});
        end
        step();
    endtask

    task automatic test_reset_mid;
        logic [F-1:0] exp;
        exp = frame_of(8'hC3);
        dato_in = 8'h5A; cargar = 1'b1;
        step();
        cargar = 1'b0;
        for (int c = 1; c < 7; c++) step();
        checks++;
        if ({listo, activo} !== 2'b01) begin
            failures++;
            $display("FAIL mid_busy got listo/activo=%b want 01", {listo, activo});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({s_out, listo, activo, fin} !== 4'b0100) begin
            failures++;
            $display("FAIL mid_async got %b want 0100", {s_out, listo, activo, fin});
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({s_out, listo, activo, fin} !== 4'b0100) begin
            failures++;
            $display("FAIL mid_no_resume got %b want 0100", {s_out, listo, activo, fin});
        end
        dato_in = 8'hC3; cargar = 1'b1;
        step();
        cargar = 1'b0;
        for (int c = 1; c <= F; c++) begin
            checks++;
            if ({s_out, listo, activo, fin} !== {exp[F-c], 3'b010}) begin
                failures++;
                $display("FAIL mid_restart c=%0d got %b want %b", c, {s_out, listo, activo, fin}, {exp[F-c], 3'b010});
            end
            step();
        end
        checks++;
        if (fin !== 1'b1) begin
            failures++;
            $display("FAIL mid_restart_fin got fin=%b want 1", fin);
        end
        step();
    endtask

    initial begin
        rst = 1'b0; cargar = 1'b0; dato_in = 8'h00;
        test_reset();
        test_single();
`ifdef GS_PARIDAD_EN
        test_parity();
`endif
        test_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
